// File: rtl/msdap_pkg.sv
// msdap_pkg: shared types and helpers for the MSDAP serial input front end
package msdap_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int DEF_DATA_W = 16;
    localparam int CNT_W      = $clog2(DEF_DATA_W);

    // word bit position of serial bit cnt
    function automatic int bit_idx(input int cnt, input int data_w, input bit msb_first);
        return msb_first ? data_w - 1 - cnt : cnt;
    endfunction

endpackage

// File: rtl/msdap_sync_fifo.sv
// msdap_sync_fifo: single-clock FIFO; a push into a full FIFO only lands when a pop frees a slot
module msdap_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   dClk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge dClk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // storage, no reset needed since dout is gated while empty
    always_ff @(posedge dClk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/serial_input_mc.sv
// serial_input_mc: multi-channel framed serial-to-parallel front end with output FIFO
module serial_input_mc
    import msdap_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic                          dClk,
    input  logic                          reset,
    input  logic                          frame,
    input  logic [NUM_CH-1:0]             data_In,
    input  logic                          out_ready,
    input  logic                          err_clr,
    output logic                          out_valid,
    output logic [NUM_CH*DATA_W-1:0]      out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int CW = $clog2(DATA_W);

    state_t                   state;
    state_t                   state_d;
    logic [CW-1:0]            cnt;
    logic [CW-1:0]            cnt_d;
    logic [NUM_CH*DATA_W-1:0] sh;
    logic [NUM_CH*DATA_W-1:0] nxt;
    logic                     capture;
    logic                     push_req;
    logic                     bad_frame;
    logic                     full;
    logic                     empty;
    int                       idx;

    // next state: frame always restarts at bit 0, mid-word frame is an error
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        capture   = 1'b0;
        push_req  = 1'b0;
        bad_frame = 1'b0;
        if (state == IDLE) begin
            if (frame) begin
                capture = 1'b1;
                cnt_d   = CW'(1);
                state_d = SHIFT;
            end
        end else if (frame) begin
            capture   = 1'b1;
            bad_frame = 1'b1;
            cnt_d     = CW'(1);
        end else begin
            capture = 1'b1;
            cnt_d   = cnt + CW'(1);
            if (cnt == CW'(DATA_W - 1)) begin
                push_req = 1'b1;
                cnt_d    = '0;
                state_d  = IDLE;
            end
        end
    end

    // merge the incoming bit of every channel into its word slot
    always_comb begin
        idx = bit_idx(frame ? 0 : int'(cnt), DATA_W, MSB_FIRST != 0);
        nxt = sh;
        for (int c = 0; c < NUM_CH; c++) nxt[c*DATA_W + idx] = data_In[c];
    end

    // FSM state and shared bit counter
    always_ff @(posedge dClk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // shift registers; stale bits of a discarded word are overwritten before the next push
    always_ff @(posedge dClk) begin
        if (reset) sh <= '0;
        else if (capture) sh <= nxt;
    end

    // sticky error flags, a new error beats err_clr
    always_ff @(posedge dClk) begin
        if (reset) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= bad_frame || (frame_err && !err_clr);
            overflow  <= (push_req && full && !(out_ready && !empty)) || (overflow && !err_clr);
        end
    end

    msdap_sync_fifo #(
        .WIDTH (NUM_CH*DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .dClk  (dClk),
        .reset (reset),
        .push  (push_req),
        .pop   (out_ready),
        .din   (nxt),
        .dout  (out_data),
        .full  (full),
        .empty (empty),
        .count (fill_level)
    );

    assign out_valid = !empty;

endmodule

// File: tb/tb_serial_input_mc.sv
// tb_serial_input_mc: vector table plus scoreboard bench for both bit orders
module tb_serial_input_mc;

    logic        dClk = 1'b0;
    logic        reset = 1'b1;
    logic        frame = 1'b0;
    logic [1:0]  data_In = '0;
    logic        out_ready = 1'b1;
    logic        err_clr = 1'b0;

    logic        valid_m, valid_l;
    logic [31:0] data_m, data_l;
    logic [2:0]  fill_m, fill_l;
    logic        ferr_m, ferr_l, ovf_m, ovf_l;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] qm[$];
    logic [31:0] ql[$];
    logic        push_pend = 1'b0;
    logic [31:0] pend_m, pend_l;
    logic        ov_exp = 1'b0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] ra;
        logic [15:0] rb;
    } vec_t;
    vec_t tab[4];

    serial_input_mc #(.NUM_CH(2), .DATA_W(16), .FIFO_DEPTH(4), .MSB_FIRST(1)) u_m (
        .dClk(dClk), .reset(reset), .frame(frame), .data_In(data_In),
        .out_ready(out_ready), .err_clr(err_clr), .out_valid(valid_m),
        .out_data(data_m), .fill_level(fill_m), .frame_err(ferr_m), .overflow(ovf_m)
    );

    serial_input_mc #(.NUM_CH(2), .DATA_W(16), .FIFO_DEPTH(4), .MSB_FIRST(0)) u_l (
        .dClk(dClk), .reset(reset), .frame(frame), .data_In(data_In),
        .out_ready(out_ready), .err_clr(err_clr), .out_valid(valid_l),
        .out_data(data_l), .fill_level(fill_l), .frame_err(ferr_l), .overflow(ovf_l)
    );

    always #5 dClk = ~dClk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rev16(input logic [15:0] x);
        for (int i = 0; i < 16; i++) rev16[i] = x[15-i];
    endfunction

    task automatic step();
        @(posedge dClk);
        #1;
        frame     = 1'b0;
        push_pend = 1'b0;
        err_clr   = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_bits(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] ra, input logic [15:0] rb,
                             input int first, input int last);
        for (int k = first; k <= last; k++) begin
            frame   = (k == 0);
            data_In = {b[15-k], a[15-k]};
            if (k == 15) begin
                push_pend = 1'b1;
                pend_m    = {b, a};
                pend_l    = {rb, ra};
            end
            step();
        end
    endtask

    task automatic send_word(input logic [15:0] a, input logic [15:0] b);
        send_bits(a, b, rev16(a), rev16(b), 0, 15);
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, "_valid"}, {valid_m, valid_l}, 2'b00);
        check({nm, "_fill"}, {fill_m, fill_l}, 6'd0);
        check({nm, "_data"}, {data_m, data_l}, 64'd0);
        check({nm, "_flags"}, {ferr_m, ovf_m, ferr_l, ovf_l}, 4'b0000);
    endtask

    // scoreboard: compare state after the last edge, then apply the coming edge
    always @(negedge dClk) begin : mon
        logic pop_e;
        logic drop;
        if (reset) begin
            qm.delete();
            ql.delete();
            ov_exp = 1'b0;
        end else begin
            check("valid_m", valid_m, qm.size() != 0);
            check("valid_l", valid_l, ql.size() != 0);
            check("fill_m", fill_m, qm.size());
            check("fill_l", fill_l, ql.size());
            check("overflow", {ovf_m, ovf_l}, {ov_exp, ov_exp});
            if (qm.size() != 0) begin
                check("head_m", data_m, qm[0]);
                check("head_l", data_l, ql[0]);
            end
            pop_e = out_ready && qm.size() != 0;
            drop  = push_pend && qm.size() == 4 && !pop_e;
            if (pop_e) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
            if (push_pend && !drop) begin
                qm.push_back(pend_m);
                ql.push_back(pend_l);
            end
            ov_exp = drop || (ov_exp && !err_clr);
        end
    end

    initial begin
        tab[0] = '{a: 16'hA5C3, b: 16'h1234, ra: 16'hC3A5, rb: 16'h2C48};
        tab[1] = '{a: 16'hFFFF, b: 16'h0000, ra: 16'hFFFF, rb: 16'h0000};
        tab[2] = '{a: 16'h8001, b: 16'h0001, ra: 16'h8001, rb: 16'h8000};
        tab[3] = '{a: 16'h00FF, b: 16'hF0F0, ra: 16'hFF00, rb: 16'h0F0F};

        reset = 1'b1;
        @(posedge dClk);
        #1;
        @(posedge dClk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;
        idle(2);

        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_bits(tab[i].a, tab[i].b, tab[i].ra, tab[i].rb, 0, 15);
        idle(3);
        check("b2b_no_ferr", {ferr_m, ferr_l}, 2'b00);

        out_ready = 1'b0;
        for (int w = 1; w <= 5; w++) send_word(16'(w), 16'(w));
        idle(1);
        check("ovf_fill", {fill_m, fill_l}, {3'd4, 3'd4});
        check("ovf_flag", {ovf_m, ovf_l}, 2'b11);
        out_ready = 1'b1;
        idle(6);
        check("ovf_drained", {valid_m, valid_l}, 2'b00);
        err_clr = 1'b1;
        step();
        check("ovf_clr", {ovf_m, ovf_l}, 2'b00);

        send_bits(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 6);
        send_word(16'h5A5A, 16'h0F1E);
        idle(1);
        check("ferr_set", {ferr_m, ferr_l}, 2'b11);
        err_clr = 1'b1;
        step();
        check("ferr_clr", {ferr_m, ferr_l}, 2'b00);
        send_bits(16'h3C3C, 16'hC3C3, 16'h3C3C, 16'hC3C3, 0, 3);
        err_clr = 1'b1;
        send_word(16'h1357, 16'h2468);
        check("ferr_set_wins", {ferr_m, ferr_l}, 2'b11);
        send_bits(16'hBEEF, 16'hCAFE, rev16(16'hBEEF), rev16(16'hCAFE), 0, 14);
        err_clr = 1'b1;
        send_bits(16'hBEEF, 16'hCAFE, rev16(16'hBEEF), rev16(16'hCAFE), 15, 15);
        check("clr_with_push", {ferr_m, ferr_l, fill_m, fill_l}, {2'b00, 3'd1, 3'd1});
        idle(3);

        out_ready = 1'b0;
        send_word(16'hAAAA, 16'h5555);
        send_word(16'h0F0F, 16'hF00F);
        send_bits(16'h7777, 16'h8888, 16'hEEEE, 16'h1111, 0, 8);
        reset = 1'b1;
        step();
        check_idle_outputs("mid_reset");
        out_ready = 1'b1;
        send_word(16'hD00D, 16'h600D);
        idle(3);

        out_ready = 1'b0;
        for (int w = 1; w <= 4; w++) send_word(16'(16'h0011 * w), 16'(16'h1100 * w));
        send_bits(16'h0055, 16'h5500, rev16(16'h0055), rev16(16'h5500), 0, 14);
        out_ready = 1'b1;
        send_bits(16'h0055, 16'h5500, rev16(16'h0055), rev16(16'h5500), 15, 15);
        check("full_pushpop", {fill_m, fill_l, ovf_m, ovf_l}, {3'd4, 3'd4, 2'b00});
        idle(8);
        check("final_empty", {valid_m, valid_l}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_input_mc.md
Name: serial_input_mc

Overview:
- Parametrised multi-channel serial-to-parallel front end for the MSDAP audio path. It replaces the single-channel, ack-driven deserializer.
- A shared frame pulse marks bit 0 of a word on every channel. The block shifts in DATA_W bits per channel and stores each completed multi-channel word in a small FIFO.
- Words are handed to the filter core over a valid/ready handshake. Framing errors and overflow are flagged.

Parameters:
- NUM_CH, 2, number of serial input channels (2 = left/right).
- DATA_W, 16, bits per sample word (range 2..32).
- FIFO_DEPTH, 4, words buffered; power of two, at least 2.
- MSB_FIRST, 1, 1: first serial bit is word MSB; 0: first bit is LSB.

Ports:
- dClk  in  1  system clock; all logic updates on its rising edge.
- reset  in  1  synchronous reset, active-high.
- frame  in  1  one-cycle pulse coincident with bit 0 of every channel.
- data_In  in  NUM_CH  serial data, one bit per channel, sampled every dClk.
- out_ready  in  1  consumer accepts out_data this cycle.
- err_clr  in  1  clears the frame_err and overflow sticky flags.
- out_valid  out  1  FIFO head is valid.
- out_data  out  NUM_CH*DATA_W  FIFO head; channel c occupies bits [c*DATA_W +: DATA_W].
- fill_level  out  $clog2(FIFO_DEPTH)+1  number of words currently held.
- frame_err  out  1  sticky: frame seen mid-word.
- overflow  out  1  sticky: completed word dropped because the FIFO was full.

Behaviour:
- Reset: one clock, synchronous, active-high. While reset=1 at a rising dClk edge:
  - all outputs go to 0 (out_valid, out_data, fill_level, frame_err, overflow);
  - bit counter goes to 0, FSM goes to IDLE, FIFO pointers are cleared.
  - Reset mid-word discards the partial word. Reset wins over every other input.
- FSM states: IDLE and SHIFT.
  - IDLE: frame=1 captures data_In as bit 0 of each channel, sets cnt=1 and moves to SHIFT. frame=0 stays in IDLE and ignores data_In.
  - SHIFT, frame=0: capture the bit and increment cnt. When cnt==DATA_W-1, capture the last bit, push the assembled word and move to IDLE.
  - SHIFT, frame=1 (premature frame): set frame_err, discard the partial word, and treat this cycle as bit 0 (cnt=1, stay in SHIFT).
  - Back-to-back words: frame=1 in the cycle after the last bit is legal and raises no error.
- Bit placement: serial bit k of a word lands at word bit DATA_W-1-k when MSB_FIRST=1, or at word bit k when MSB_FIRST=0. All channels use the same counter.
- FIFO push/pop rules:
  - Push happens in the cycle the last bit is captured. The word is visible at out_data with out_valid=1 on the next cycle when the FIFO was empty (latency: 1 dClk after the last bit).
  - Pop happens when out_valid and out_ready are both 1. out_data/out_valid must not change while out_valid=1 and out_ready=0.
  - Full with push and no pop: the new word is dropped, overflow is set, FIFO contents are unchanged.
  - Full with push and pop in the same cycle: both take effect; fill_level stays at FIFO_DEPTH and overflow is not set.
  - Empty with push and pop in the same cycle: the pop is ignored because out_valid=0 that cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - fill_level is updated in the same edge as push/pop.
- Error flags:
  - err_clr=1 clears frame_err and overflow.
  - A new error in the same cycle as err_clr leaves the flag set (set wins).
- Simultaneous last-bit push and err_clr: the push proceeds normally.

Decomposition:
- Shared package msdap_pkg holds:
  - state_t enum {IDLE, SHIFT};
  - localparam CNT_W = $clog2(DATA_W);
  - a function for bit index from count and MSB_FIRST.
- One sub-module: msdap_sync_fifo.
  - Parameters: WIDTH, DEPTH.
  - Ports: push/pop, din/dout, full/empty, count.
  - Same dClk/reset.
- The top level keeps the FSM, shift registers and flags.

Test Plan:
- Default params; frame pulse, then 16 bits per channel: ch0=0xA5C3 and ch1=0x1234, MSB first; out_ready=1. Required: out_valid=1 exactly 1 cycle after the last bit, out_data=0x1234_A5C3, fill_level returns to 0, no flags.
- MSB_FIRST=0; same serial bit stream. Required: each channel is bit-reversed, ch0=0xC3A5, ch1=0x2C48.
- out_ready=0; 5 back-to-back words 0x0001..0x0005 on both channels. Required:
  - fill_level reaches 4;
  - overflow=1 after the fifth word;
  - releasing out_ready drains 0x0001..0x0004 in order, then out_valid=0.
- Frame re-asserted at bit 7 of a word. Required:
  - frame_err=1, partial word not pushed;
  - the following 16 bits form a correct word;
  - err_clr for one cycle returns frame_err to 0.
- Reset asserted at bit 9 with 2 words already queued. Required: next edge gives all outputs 0 and fill_level=0; a fresh frame produces a correct word afterwards.
- FIFO full with out_ready=1 and a push completing in the same cycle. Required: no overflow, fill_level stays 4, word order preserved.
